// File: rtl/laa_engine.sv
// LAA register file and opcode executor: WRITE/READ in one cycle, iterative shift-add MULTIPLY.
// Define LAA_MUL_HI_EN to also write the product high word to reg[dst+1] in a second write-back cycle.
module laa_engine #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [1:0]        opcode,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              mul_done
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_MUL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB, S_WB_HI} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   a_q, b_q;
  logic [ADDR_W-1:0]   dst;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                last_step;

  assign accept    = op_valid && op_ready && (opcode != OP_NONE);
  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept && opcode == OP_MUL) next_state = S_MUL;
      S_MUL:  if (last_step) next_state = S_WB;
`ifdef LAA_MUL_HI_EN
      S_WB:    next_state = S_WB_HI;
      S_WB_HI: next_state = S_IDLE;
`else
      S_WB:    next_state = S_IDLE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state == S_IDLE);
`ifdef LAA_MUL_HI_EN
    mul_done = (state == S_WB_HI);
`else
    mul_done = (state == S_WB);
`endif
  end

  // Operands are captured at accept, so the destination may alias either source.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      dst      <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (opcode)
              OP_WRITE: regs[addr] <= data_in;
              OP_READ: begin
                data_out <= regs[addr];
                rd_valid <= 1'b1;
              end
              OP_MUL: begin
                a_q <= regs[addr_a];
                b_q <= regs[addr_b];
                dst <= addr;
                acc <= '0;
                cnt <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (b_q[cnt]) acc <= acc + ({{DATA_W{1'b0}}, a_q} << cnt);
          cnt <= cnt + 1'b1;
        end
        S_WB: regs[dst] <= acc[DATA_W-1:0];
`ifdef LAA_MUL_HI_EN
        S_WB_HI: regs[dst + ADDR_W'(1)] <= acc[2*DATA_W-1:DATA_W];
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/laa_engine.md
Name: laa_engine

Overview:
- Responder side of the LAA bus: holds the LAA register file and executes the opcodes issued by the core-side LAA decoder.
- WRITE stores a core operand into an LAA register. READ returns an LAA register value. MULTIPLY runs an iterative shift-add multiply between two LAA registers and writes the product back.
- Sits directly behind the LAA bus, one clock domain with the core.

Parameters:
- DATA_W, 32, operand/register width in bits.
- NUM_REGS, 32, number of LAA registers; must be a power of two.
- ADDR_W, 5, register address width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- opcode  input  2  NONE=0, READ=1, WRITE=2, MULTIPLY=3.
- op_valid  input  1  request present this cycle.
- op_ready  output  1  engine can accept a request.
- addr  input  ADDR_W  WRITE/READ target register; MULTIPLY destination.
- addr_a  input  ADDR_W  MULTIPLY source A.
- addr_b  input  ADDR_W  MULTIPLY source B.
- data_in  input  DATA_W  WRITE data.
- data_out  output  DATA_W  READ result (registered).
- rd_valid  output  1  one-cycle pulse: data_out holds a new READ result.
- mul_done  output  1  one-cycle pulse: multiply result written.

Behaviour:
- Reset (Rst=0, async): state=IDLE, all registers=0, data_out=0, rd_valid=0, mul_done=0, op_ready=1; counter/accumulator cleared.
- Reset mid-multiply: the multiply is aborted and no write-back occurs.
- Accept: a request is taken on a rising edge with op_valid=1, op_ready=1 and opcode!=NONE. NONE is ignored with no state change.
- op_ready=1 only in IDLE, so requests presented during MUL or WB are not accepted and the initiator must hold them.
- States: IDLE, MUL, WB.
- WRITE (IDLE->IDLE): reg[addr]<=data_in at the accept edge. Visible to a READ accepted on the following cycle.
- READ (IDLE->IDLE): data_out<=reg[addr] at the accept edge; rd_valid=1 for the next cycle only.
  - data_out holds its value until the next READ.
  - WRITE then READ of the same address in back-to-back cycles returns the new data.
- MULTIPLY (IDLE->MUL):
  - At the accept edge, latch A=reg[addr_a], B=reg[addr_b] and dst=addr. Operands are captured, so dst may alias addr_a/addr_b.
  - Set acc=0 and cnt=0.
- MUL: each cycle, if B[cnt]=1 then acc+=A<<cnt (2*DATA_W-bit accumulator, unsigned). cnt++. When cnt==DATA_W-1, go to WB after that step.
- MUL length: exactly DATA_W cycles.
- WB (one cycle): reg[dst]<=acc[DATA_W-1:0] at the end of the cycle; mul_done=1 during WB; next state IDLE.
- Latency: op_ready is low for DATA_W+1 cycles after the accept edge. A new request can be accepted at edge DATA_W+2 and sees the product.
- Arithmetic: unsigned; the product is truncated to the low DATA_W bits.
- rd_valid and mul_done are never high simultaneously.

Optional Feature:
- Macro LAA_MUL_HI_EN.
- Defined: WB takes two cycles (WB_LO, WB_HI).
  - WB_LO writes acc[DATA_W-1:0] to reg[dst].
  - WB_HI writes acc[2*DATA_W-1:DATA_W] to reg[(dst+1) mod NUM_REGS], wrapping 31->0.
  - mul_done pulses in WB_HI only; op_ready is low for DATA_W+2 cycles.
- Undefined: single WB as above; the high word is discarded and no second register is touched.

Test Plan:
- Reset, then READ addr 7 -> data_out=0, rd_valid pulses one cycle after accept; op_ready=1.
- WRITE reg3=0xDEADBEEF, next cycle READ reg3 -> data_out=0xDEADBEEF; a NONE with op_valid=1 in between leaves all registers unchanged.
- reg1=6, reg2=7, MULTIPLY dst=4 a=1 b=2 -> op_ready low 33 cycles, mul_done pulses once, READ reg4=42. Holding a WRITE valid during busy is not accepted until op_ready returns.
- reg5=0xFFFFFFFF, MULTIPLY dst=5 a=5 b=5 -> reg5=0x00000001.
  - With LAA_MUL_HI_EN: reg6=0xFFFFFFFE.
  - Same test with dst=31: high word lands in reg0.
- Start MULTIPLY dst=8, assert Rst low at cycle 10 of MUL -> reg8=0, op_ready=1 immediately, mul_done never pulses.
- READ of reg9 concurrent with in-flight multiply (op_valid held) -> accepted the cycle after mul_done, returns post-multiply register contents.
